// File: rtl/offchip_mem_model.sv
// offchip_mem_model: two-channel, byte-wide, fixed-latency memory model that
// answers the master bus of the HLS core, with a preload port and a debug port.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   Mout_oe_ram[1:0]      - per-channel read request
//   Mout_we_ram[1:0]      - per-channel write request
//   Mout_addr_ram         - channel c address at [c*ADDR_W +: ADDR_W]
//   Mout_Wdata_ram        - channel c write byte at [c*8 +: 8]
//   Mout_data_ram_size    - channel c bit count at [c*4 +: 4] (mask (1<<n)-1)
//   M_Rdata_ram           - channel c read byte at [c*8 +: 8]
//   M_DataRdy[1:0]        - per-channel access-complete strobe
//   init_we/idx/wdata     - preload write, index relative to BASE_ADDR
//   dbg_idx, dbg_rdata    - combinational debug read (0 when out of range)
//   err_both              - sticky: some channel requested read and write together
module offchip_mem_model #(
    parameter int BASE_ADDR   = 0,
    parameter int MEMSIZE     = 32,
    parameter int ADDR_W      = 7,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [15:0]           Mout_Wdata_ram,
    input  logic [7:0]            Mout_data_ram_size,
    output logic [15:0]           M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    input  logic                  init_we,
    input  logic [ADDR_W-1:0]     init_idx,
    input  logic [7:0]            init_wdata,
    input  logic [ADDR_W-1:0]     dbg_idx,
    output logic [7:0]            dbg_rdata,
    output logic                  err_both
);

    localparam int MAX_D  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W  = $clog2(MAX_D + 1);
    localparam int IDX_W  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int PIPE_N = READ_DELAY - 1;

    localparam logic [ADDR_W:0]  BASE_X  = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]  SIZE_X  = (ADDR_W + 1)'(MEMSIZE);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);

    logic [7:0]       mem   [MEMSIZE];
    logic [ADDR_W:0]  off   [2];
    logic [IDX_W-1:0] idx   [2];
    logic [7:0]       rbyte [2];
    logic [7:0]       wmask [2];
    logic [7:0]       wbyte [2];
    logic [CNT_W-1:0] cnt   [2];
    logic [7:0]       pipe  [2][PIPE_N];
    logic [1:0]       hit;
    logic [1:0]       legal;
    logic [1:0]       go_wr;
    logic [1:0]       rdy;
    logic             err_q;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            // Offset is taken one bit wider than the address: an address
            // below BASE_ADDR wraps to a value above any legal offset, so a
            // single unsigned compare covers both window bounds.
            off[c]   = {1'b0, Mout_addr_ram[c*ADDR_W +: ADDR_W]} - BASE_X;
            hit[c]   = off[c] < SIZE_X;
            idx[c]   = off[c][IDX_W-1:0];
            legal[c] = !(Mout_oe_ram[c] && Mout_we_ram[c]);
            rbyte[c] = hit[c] ? mem[idx[c]] : 8'h00;
            wmask[c] = 8'((16'd1 << Mout_data_ram_size[c*4 +: 4]) - 16'd1);
            wbyte[c] = (Mout_Wdata_ram[c*8 +: 8] & wmask[c])
                     | (mem[idx[c]] & ~wmask[c]);
            go_wr[c] = !reset && hit[c] && legal[c] && Mout_we_ram[c];
            rdy[c]   = !reset && hit[c] && legal[c]
                     && (Mout_oe_ram[c] ? (cnt[c] == RD_LAST)
                                        : (Mout_we_ram[c] && cnt[c] == WR_LAST));
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (reset || !hit[c] || !legal[c]
                || !(Mout_oe_ram[c] || Mout_we_ram[c])) begin
                cnt[c] <= '0;
            end else if (Mout_oe_ram[c]) begin
                cnt[c] <= (cnt[c] == RD_LAST) ? '0 : cnt[c] + 1'b1;
            end else begin
                cnt[c] <= (cnt[c] == WR_LAST) ? '0 : cnt[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < PIPE_N; i++)
                    pipe[c][i] <= 8'h00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                pipe[c][0] <= rbyte[c];
                for (int i = 1; i < PIPE_N; i++)
                    pipe[c][i] <= pipe[c][i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            err_q <= 1'b0;
        else if (|(Mout_oe_ram & Mout_we_ram))
            err_q <= 1'b1;
    end

    // Later assignments win on a shared byte: preload, then ch0, then ch1.
    // Memory has no reset so a preload done before reset survives it.
    always_ff @(posedge clock) begin
        if (init_we && ({1'b0, init_idx} < SIZE_X))
            mem[init_idx[IDX_W-1:0]] <= init_wdata;
        for (int c = 0; c < 2; c++)
            if (go_wr[c])
                mem[idx[c]] <= wbyte[c];
    end

    assign dbg_rdata   = ({1'b0, dbg_idx} < SIZE_X) ? mem[dbg_idx[IDX_W-1:0]] : 8'h00;
    assign M_Rdata_ram = {pipe[1][PIPE_N-1], pipe[0][PIPE_N-1]};
    assign M_DataRdy   = rdy;
    assign err_both    = err_q;

endmodule

// File: doc/offchip_mem_model.md
# offchip_mem_model

Two-channel, byte-wide, fixed-latency off-chip memory model that sits directly downstream of the HLS top `main`. It consumes the core's master bus (`Mout_*`) and returns read data and per-channel ready strobes (`M_Rdata_ram`, `M_DataRdy`). It replaces the inline memory behaviour of the simulation bench with a reusable, separately verifiable block. It also provides a preload port and a debug read port for the bench.

## Interface

Parameters:
- `BASE_ADDR`, 0: first byte address served.
- `MEMSIZE`, 32: number of bytes; the window is `[BASE_ADDR, BASE_ADDR+MEMSIZE)`.
- `ADDR_W`, 7: per-channel address width.
- `READ_DELAY`, 2: read latency in cycles; must be ≥2.
- `WRITE_DELAY`, 1: write acknowledge latency in cycles; must be ≥1.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `Mout_oe_ram`  in  2  read request, one bit per channel.
- `Mout_we_ram`  in  2  write request, one bit per channel.
- `Mout_addr_ram`  in  2*ADDR_W  channel c address at `[c*ADDR_W +: ADDR_W]`.
- `Mout_Wdata_ram`  in  16  channel c write byte at `[c*8 +: 8]`.
- `Mout_data_ram_size`  in  8  channel c bit count at `[c*4 +: 4]`; write mask is `(1<<size)-1`.
- `M_Rdata_ram`  out  16  channel c read byte.
- `M_DataRdy`  out  2  per-channel access-complete strobe.
- `init_we`  in  1  preload write enable.
- `init_idx`  in  ADDR_W  preload byte index, offset from `BASE_ADDR`.
- `init_wdata`  in  8  preload byte.
- `dbg_idx`  in  ADDR_W  debug read index.
- `dbg_rdata`  out  8  combinational `mem[dbg_idx]`; returns 0 if `dbg_idx ≥ MEMSIZE`.
- `err_both`  out  1  sticky flag: some channel had `oe` and `we` high in the same cycle.

## Operation

- **In-range test (per channel c):** `hit[c] = BASE_ADDR ≤ addr_c < BASE_ADDR+MEMSIZE`. Compute it at ADDR_W+1 bits so that `BASE_ADDR+MEMSIZE` cannot wrap.
- **Illegal request:** if `oe[c]` and `we[c]` are both high:
  - the access is ignored;
  - `M_DataRdy[c]` = 0;
  - `err_both` is set and held until reset.
- **Per-channel counter `cnt[c]`:**
  - while the access is legal and `hit[c]`: wraps to 0 at `DELAY-1`, otherwise increments;
  - `DELAY` is `READ_DELAY` for reads and `WRITE_DELAY` for writes;
  - in any other cycle it loads 0.
- **Ready strobe:** `M_DataRdy[c] = hit[c] & legal & (oe[c] ? cnt[c]==READ_DELAY-1 : we[c] & cnt[c]==WRITE_DELAY-1)`. This is combinational from registered state and the request.
- **Read path:**
  - every cycle, `mem[addr_c-BASE_ADDR]` (0 if `!hit[c]`) enters a shift pipeline of `READ_DELAY-1` stages;
  - `M_Rdata_ram[c]` is the oldest stage.
  - The master holds its request stable until it sees `M_DataRdy[c]`.
- **Write path:**
  - on every edge where `we[c] & hit[c] & legal`, do `mem[idx] = (wdata & mask) | (mem[idx] & ~mask)`;
  - with `WRITE_DELAY>1` the write repeats each held cycle, which is idempotent.
- **Write priority on the same byte, same edge:** channel 1 > channel 0 > preload.
- **Preload:** `init_we` with `init_idx < MEMSIZE` writes the full byte; an out-of-range index is ignored.
- **Reset:**
  - `cnt` = 0, read pipeline = 0, `err_both` = 0;
  - memory contents are preserved, so a preload may precede reset;
  - reset mid-access aborts it with no `M_DataRdy` pulse.

## Timing

- **Reset values:**
  - `M_Rdata_ram` = 0 and `err_both` = 0 from the edge after `reset`;
  - `M_DataRdy` = 0 while `reset` is high.
- **Read latency:** request in cycle t; `M_DataRdy` and valid `M_Rdata_ram` in cycle t+READ_DELAY-1. Example: `READ_DELAY=2` gives data in t+1.
- **Write latency:** `M_DataRdy` in cycle t+WRITE_DELAY-1 (same cycle for 1). Memory is updated at the end of cycle t.
- **Back-to-back requests:** after the ready cycle `cnt` is 0, so a new request in the next cycle starts a fresh count.
- **Channel independence:** the channels have independent counters; simultaneous reads on both channels complete in the same cycle.
- **Read after write:** a read issued in the cycle after a write returns the new byte.

## Test plan

- **Preload and read:** preload idx 5 = 0xA7, `BASE_ADDR=0`; ch0 `oe`, addr 5 at t → `M_DataRdy[0]`=1 and `M_Rdata_ram[7:0]`=0xA7 at t+1; `M_DataRdy[0]`=0 at t.
- **Masked write:** mem[3]=0xFF; ch1 `we`, addr 3, wdata 0x12, size 4 → `M_DataRdy[1]`=1 the same cycle; `dbg_rdata` at idx 3 = 0xF2.
- **Out of range:** addr 40 with `MEMSIZE=32` → `M_DataRdy`=0 indefinitely, `M_Rdata_ram`=0, memory unchanged.
- **Same-byte write collision:** ch0 and ch1 both write idx 7 (0x11 / 0x22, size 8) on the same edge as preload 0x33 → mem[7]=0x22.
- **Illegal request:** `oe[0]=we[0]=1` → `err_both`=1 from the next cycle and stays 1 after the request drops; `reset` clears it.
- **Reset mid-read:** `READ_DELAY=4`; reset asserted at t+1 of a read → no ready pulse; after reset, a read of the same address completes at t'+3 with the correct data.
